// File: rtl/accum_block_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : accum_block_ram_if
// Purpose  : Op handshake, readout and clear-control bundle for accum_block_ram.
// Revision : 1.0
// ============================================================================
interface accum_block_ram_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int IN_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_accumulate;
    logic [ADDRESS_WIDTH-1:0] in_address;
    logic [IN_WIDTH-1:0]      in_data;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     clear_start;
    logic                     busy;
    logic                     overflow;

    modport master (
        output in_valid, in_accumulate, in_address, in_data, read_address, clear_start,
        input  in_ready, read_data, busy, overflow
    );

    modport slave (
        input  in_valid, in_accumulate, in_address, in_data, read_address, clear_start,
        output in_ready, read_data, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/accum_block_ram.sv
`default_nettype none
// ============================================================================
// Module   : accum_block_ram
// Purpose  : Dual-port RAM with write/accumulate ops, clear sweep and readout.
//            Build option: ACCUM_BLOCK_RAM_SATURATE_EN saturates on overflow.
// Revision : 1.0
// ============================================================================
module accum_block_ram #(
    parameter int DATA_WIDTH    = 16,
    parameter int IN_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DEPTH         = 256
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    accum_block_ram_if.slave  bus
);

    localparam logic [ADDRESS_WIDTH:0]   c_depth_ext = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_cnt;
    logic [ADDRESS_WIDTH-1:0] w_cnt_next;
    logic                     w_clear_go;
    logic                     w_accept;

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    logic                     r_s0_valid;
    logic [ADDRESS_WIDTH-1:0] r_s0_addr;
    logic [IN_WIDTH-1:0]      r_s0_data;
    logic                     r_s0_acc;
    logic [DATA_WIDTH-1:0]    r_s0_old;

    logic [DATA_WIDTH:0]      w_sum;
    logic                     w_ovf;
    logic [DATA_WIDTH-1:0]    w_acc_val;
    logic [DATA_WIDTH-1:0]    w_result;
    logic                     w_s0_in_range;
    logic                     w_forward;

    logic                     r_overflow;
    logic [DATA_WIDTH-1:0]    r_read_data;

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_CLEAR);
    assign bus.overflow  = r_overflow;
    assign bus.read_data = r_read_data;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    // ---------------- clear sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clear_go   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    w_clear_go   = 1'b1;
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == c_last_addr) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- stage 1 result ----------------
    always_comb begin
        w_sum = (DATA_WIDTH+1)'(r_s0_old) + (DATA_WIDTH+1)'(r_s0_data);
        w_ovf = r_s0_acc && w_sum[DATA_WIDTH];
`ifdef ACCUM_BLOCK_RAM_SATURATE_EN
        w_acc_val = w_ovf ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
`else
        w_acc_val = w_sum[DATA_WIDTH-1:0];
`endif
        w_result      = r_s0_acc ? w_acc_val : DATA_WIDTH'(r_s0_data);
        w_s0_in_range = ({1'b0, r_s0_addr} < c_depth_ext);
        // Stage 0 must see the word stage 1 is committing this same edge.
        w_forward     = r_s0_valid && w_s0_in_range && (r_s0_addr == bus.in_address);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_clear_go) begin
                r_overflow <= 1'b0;
            end else if (r_s0_valid && w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_addr <= bus.in_address;
            r_s0_data <= bus.in_data;
            r_s0_acc  <= bus.in_accumulate;
            r_s0_old  <= w_forward ? w_result : r_mem[bus.in_address];
        end
    end

    // Sweep write comes last so it overrides an op committing on the first sweep edge.
    always_ff @(posedge clk) begin
        if (r_s0_valid && w_s0_in_range) begin
            r_mem[r_s0_addr] <= w_result;
        end
        if (rst_n && (r_state == ST_CLEAR)) begin
            r_mem[r_cnt] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_data <= '0;
        end else begin
            r_read_data <= r_mem[bus.read_address];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_block_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_block_ram
// Purpose  : Directed self-checking bench for accum_block_ram.
// Revision : 1.0
// ============================================================================
module tb_accum_block_ram;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    accum_block_ram_if #(.DATA_WIDTH(16), .IN_WIDTH(8), .ADDRESS_WIDTH(8)) bus ();

    accum_block_ram #(
        .DATA_WIDTH(16), .IN_WIDTH(8), .ADDRESS_WIDTH(8), .DEPTH(256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] d, input logic acc);
        bus.in_valid      = 1'b1;
        bus.in_address    = a;
        bus.in_data       = d;
        bus.in_accumulate = acc;
        step();
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_accumulate = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
        bus.read_address = a;
        step();
        chk(tag, {16'h0, bus.read_data}, {16'h0, exp});
    endtask

    task automatic wait_sweep_done();
        int n;
        n = 0;
        while (bus.busy && n < 1000) begin
            step();
            n++;
        end
        chk("sweep_timeout", {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        int busy_cycles;
        int ready_viol;
        logic [15:0] ovf_exp;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_accumulate = 1'b0;
        bus.in_address    = '0;
        bus.in_data       = '0;
        bus.read_address  = '0;
        bus.clear_start   = 1'b0;
        step();
        step();
        chk("rst_read_data", {16'h0, bus.read_data}, 32'h0);
        chk("rst_busy",      {31'h0, bus.busy},      32'h0);
        chk("rst_overflow",  {31'h0, bus.overflow},  32'h0);
        chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
        rst_n = 1'b1;
        step();

        // Full clear sweep: busy exactly 256 cycles, in_ready low throughout.
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        busy_cycles = 0;
        ready_viol  = 0;
        while (bus.busy && busy_cycles < 1000) begin
            if (bus.in_ready) ready_viol++;
            busy_cycles++;
            step();
        end
        chk("busy_cycles",  busy_cycles, 256);
        chk("ready_in_clr", ready_viol, 0);
        chk("ready_after",  {31'h0, bus.in_ready}, 32'h1);
        for (int i = 0; i < 256; i++) rd("clr_rd", 8'(i), 16'h0000);

        // Plain write.
        op(8'd3, 8'hA5, 1'b0);
        idle();
        step();
        rd("write_a5", 8'd3, 16'h00A5);

        // Back-to-back accumulates to one address.
        repeat (4) op(8'd7, 8'h10, 1'b1);
        idle();
        step();
        rd("b2b_acc", 8'd7, 16'h0040);

        // Interleaved accumulates to 7/8.
        op(8'd7, 8'h00, 1'b0);
        op(8'd8, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op(8'd7, 8'h01, 1'b1);
            op(8'd8, 8'h01, 1'b1);
        end
        idle();
        step();
        rd("inter_7", 8'd7, 16'h0003);
        rd("inter_8", 8'd8, 16'h0003);

        // Preload 0xFFF0 = 0xF0 + 256*0xFF, then overflow it.
        op(8'd1, 8'hF0, 1'b0);
        repeat (256) op(8'd1, 8'hFF, 1'b1);
        idle();
        step();
        rd("preload", 8'd1, 16'hFFF0);
        chk("no_ovf_yet", {31'h0, bus.overflow}, 32'h0);
        op(8'd1, 8'h20, 1'b1);
        idle();
        step();
        chk("ovf_set", {31'h0, bus.overflow}, 32'h1);
`ifdef ACCUM_BLOCK_RAM_SATURATE_EN
        ovf_exp = 16'hFFFF;
`else
        ovf_exp = 16'h0010;
`endif
        rd("ovf_value", 8'd1, ovf_exp);
        op(8'd2, 8'h01, 1'b1);
        idle();
        step();
        chk("ovf_sticky", {31'h0, bus.overflow}, 32'h1);
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        chk("ovf_cleared", {31'h0, bus.overflow}, 32'h0);
        chk("clr_busy",    {31'h0, bus.busy},     32'h1);
        wait_sweep_done();

        // Read-first on a same-edge commit.
        op(8'd9, 8'h11, 1'b0);
        idle();
        step();
        bus.read_address = 8'd9;
        op(8'd9, 8'h55, 1'b0);
        idle();
        step();
        chk("read_first_old", {16'h0, bus.read_data}, 32'h0011);
        step();
        chk("read_first_new", {16'h0, bus.read_data}, 32'h0055);

        // Reset mid-sweep; op accepted with clear_start is overwritten by the sweep.
        op(8'd200, 8'h77, 1'b0);
        op(8'd50,  8'h33, 1'b0);
        idle();
        step();
        bus.clear_start = 1'b1;
        op(8'd0, 8'h99, 1'b0);
        idle();
        bus.clear_start = 1'b0;
        repeat (100) step();
        chk("mid_busy", {31'h0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        step();
        chk("abort_busy",   {31'h0, bus.busy},      32'h0);
        chk("abort_ready",  {31'h0, bus.in_ready},  32'h1);
        chk("abort_rdata",  {16'h0, bus.read_data}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) rd("abort_clr", 8'(i), 16'h0000);
        rd("abort_keep200", 8'd200, 16'h0077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
